// File: rtl/control_unit_pipelined.sv
// control_unit_pipelined: ID-stage ARM decoder with condition-field evaluation,
// feeding a registered ID/EX control bundle. Handles downstream stall, flush and
// flag-hazard bubbles. Optional saturating performance counters are built when
// the macro CU_PERF_CNT_EN is defined.
module control_unit_pipelined #(
   parameter int unsigned CNT_W    = 16,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instruction,
   input  logic              instr_valid,
   input  logic [3:0]        flags_nzcv,
   input  logic              stall,
   input  logic              flush,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic              ex_cond_pass,
   output logic              ex_reg_write_enable,
   output logic              ex_mem_enable,
   output logic              ex_mem_rw,
   output logic              ex_mem_to_reg_select,
   output logic              ex_alu_source_select,
   output logic              ex_status_bit,
   output logic              ex_pc_source_select,
   output logic              ex_mem_size,
   output logic [3:0]        ex_alu_operation
`ifdef CU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  perf_issued,
   output logic [CNT_W-1:0]  perf_squashed,
   output logic [CNT_W-1:0]  perf_bubbles
`endif
);

   typedef enum logic [1:0] {
      CLS_DP  = 2'b00,
      CLS_MEM = 2'b01,
      CLS_BR  = 2'b10,
      CLS_SYS = 2'b11
   } instr_class_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_ADC = 4'b0001,
      ALU_SUB = 4'b0010,
      ALU_SBC = 4'b0011,
      ALU_RSB = 4'b0100,
      ALU_RSC = 4'b0101,
      ALU_AND = 4'b0110,
      ALU_ORR = 4'b0111,
      ALU_EOR = 4'b1000,
      ALU_MOV = 4'b1010,
      ALU_MVN = 4'b1011,
      ALU_BIC = 4'b1100
   } alu_op_e;

   typedef struct packed {
      logic       valid;
      logic       cond_pass;
      logic       reg_write;
      logic       mem_en;
      logic       mem_rw;
      logic       mem_to_reg;
      logic       alu_src;
      logic       status;
      logic       pc_src;
      logic       mem_size;
      logic [3:0] alu_op;
   } ctrl_t;

   // Data-processing opcode (bits 24:21) to ALU operation code
   function automatic alu_op_e dp_alu_map(input logic [3:0] opcode);
      alu_op_e op;
      case (opcode)
         4'h0:    op = ALU_AND;
         4'h1:    op = ALU_EOR;
         4'h2:    op = ALU_SUB;
         4'h3:    op = ALU_RSB;
         4'h4:    op = ALU_ADD;
         4'h5:    op = ALU_ADC;
         4'h6:    op = ALU_SBC;
         4'h7:    op = ALU_RSC;
         4'h8:    op = ALU_AND;   // TST
         4'h9:    op = ALU_EOR;   // TEQ
         4'hA:    op = ALU_SUB;   // CMP
         4'hB:    op = ALU_ADD;   // CMN
         4'hC:    op = ALU_ORR;
         4'hD:    op = ALU_MOV;
         4'hE:    op = ALU_BIC;
         default: op = ALU_MVN;
      endcase
      return op;
   endfunction

   // ARM condition codes; 4'hF is treated as never
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, r;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond)
         4'h0:    r = z;
         4'h1:    r = ~z;
         4'h2:    r = c;
         4'h3:    r = ~c;
         4'h4:    r = n;
         4'h5:    r = ~n;
         4'h6:    r = v;
         4'h7:    r = ~v;
         4'h8:    r = c & ~z;
         4'h9:    r = ~c | z;
         4'hA:    r = (n == v);
         4'hB:    r = (n != v);
         4'hC:    r = ~z & (n == v);
         4'hD:    r = z | (n != v);
         4'hE:    r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   instr_class_e cls;
   logic         cond_ok;
   logic         is_nop;
   ctrl_t        dec;
   ctrl_t        ex_q;

   assign cls     = instr_class_e'(instruction[27:26]);
   assign cond_ok = cond_eval(instruction[31:28], flags_nzcv);
   assign is_nop  = (instruction == NOP_WORD);

   // Decode the ID-stage instruction into the next EX control bundle
   always_comb begin
      dec           = '0;
      dec.valid     = 1'b1;
      dec.cond_pass = cond_ok;
      case (cls)
         CLS_DP: begin
            dec.reg_write = (instruction[24:23] != 2'b10);
            dec.status    = instruction[20];
            dec.alu_src   = instruction[25];
            dec.alu_op    = dp_alu_map(instruction[24:21]);
         end
         CLS_MEM: begin
            dec.mem_en   = 1'b1;
            dec.alu_src  = ~instruction[25];
            dec.alu_op   = instruction[23] ? ALU_ADD : ALU_SUB;
            dec.mem_size = instruction[22];
            if (instruction[20]) begin
               dec.reg_write  = 1'b1;
               dec.mem_to_reg = 1'b1;
            end else begin
               dec.mem_rw = 1'b1;
            end
         end
         CLS_BR: begin
            dec.pc_src    = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = ALU_ADD;
            dec.reg_write = instruction[24];
         end
         default: ;
      endcase
      // NOP overrides decode entirely; a failed condition only kills side effects
      if (is_nop) begin
         dec           = '0;
         dec.valid     = 1'b1;
      end else if (!cond_ok) begin
         dec.cond_pass  = 1'b0;
         dec.reg_write  = 1'b0;
         dec.mem_en     = 1'b0;
         dec.mem_rw     = 1'b0;
         dec.mem_to_reg = 1'b0;
         dec.status     = 1'b0;
         dec.pc_src     = 1'b0;
      end
   end

   assign hazard_stall = instr_valid & ex_q.valid & ex_q.status &
                         (instruction[31:28] != 4'hE) & ~stall & ~flush;

   // ID/EX register: flush > stall > hazard bubble > idle bubble > load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q <= '0;
      end else if (flush) begin
         ex_q <= '0;
      end else if (stall) begin
         ex_q <= ex_q;
      end else if (hazard_stall || !instr_valid) begin
         ex_q <= '0;
      end else begin
         ex_q <= dec;
      end
   end

   assign ex_valid             = ex_q.valid;
   assign ex_cond_pass         = ex_q.cond_pass;
   assign ex_reg_write_enable  = ex_q.reg_write;
   assign ex_mem_enable        = ex_q.mem_en;
   assign ex_mem_rw            = ex_q.mem_rw;
   assign ex_mem_to_reg_select = ex_q.mem_to_reg;
   assign ex_alu_source_select = ex_q.alu_src;
   assign ex_status_bit        = ex_q.status;
   assign ex_pc_source_select  = ex_q.pc_src;
   assign ex_mem_size          = ex_q.mem_size;
   assign ex_alu_operation     = ex_q.alu_op;

`ifdef CU_PERF_CNT_EN
   logic             load_en;
   logic             inc_issued;
   logic             inc_squashed;
   logic             inc_bubbles;
   logic [CNT_W-1:0] cnt_issued;
   logic [CNT_W-1:0] cnt_squashed;
   logic [CNT_W-1:0] cnt_bubbles;

   assign load_en      = ~flush & ~stall & ~hazard_stall & instr_valid;
   assign inc_issued   = load_en & dec.cond_pass;
   assign inc_squashed = (load_en & ~dec.cond_pass & ~is_nop) | (flush & ex_q.valid);
   assign inc_bubbles  = hazard_stall;

   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_issued   <= '0;
         cnt_squashed <= '0;
         cnt_bubbles  <= '0;
      end else begin
         if (inc_issued && cnt_issued != '1)
            cnt_issued <= cnt_issued + CNT_W'(1);
         if (inc_squashed && cnt_squashed != '1)
            cnt_squashed <= cnt_squashed + CNT_W'(1);
         if (inc_bubbles && cnt_bubbles != '1)
            cnt_bubbles <= cnt_bubbles + CNT_W'(1);
      end
   end

   assign perf_issued   = cnt_issued;
   assign perf_squashed = cnt_squashed;
   assign perf_bubbles  = cnt_bubbles;
`endif

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Directed testbench for control_unit_pipelined; counter checks are compiled in
// when CU_PERF_CNT_EN is defined.
module tb_control_unit_pipelined;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic        instr_valid;
   logic [3:0]  flags_nzcv;
   logic        stall;
   logic        flush;
   logic        hazard_stall;
   logic        ex_valid;
   logic        ex_cond_pass;
   logic        ex_reg_write_enable;
   logic        ex_mem_enable;
   logic        ex_mem_rw;
   logic        ex_mem_to_reg_select;
   logic        ex_alu_source_select;
   logic        ex_status_bit;
   logic        ex_pc_source_select;
   logic        ex_mem_size;
   logic [3:0]  ex_alu_operation;
`ifdef CU_PERF_CNT_EN
   logic [3:0]  perf_issued;
   logic [3:0]  perf_squashed;
   logic [3:0]  perf_bubbles;
`endif

   int checks = 0;
   int errors = 0;

   control_unit_pipelined #(
      .CNT_W    (4),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .instruction          (instruction),
      .instr_valid          (instr_valid),
      .flags_nzcv           (flags_nzcv),
      .stall                (stall),
      .flush                (flush),
      .hazard_stall         (hazard_stall),
      .ex_valid             (ex_valid),
      .ex_cond_pass         (ex_cond_pass),
      .ex_reg_write_enable  (ex_reg_write_enable),
      .ex_mem_enable        (ex_mem_enable),
      .ex_mem_rw            (ex_mem_rw),
      .ex_mem_to_reg_select (ex_mem_to_reg_select),
      .ex_alu_source_select (ex_alu_source_select),
      .ex_status_bit        (ex_status_bit),
      .ex_pc_source_select  (ex_pc_source_select),
      .ex_mem_size          (ex_mem_size),
      .ex_alu_operation     (ex_alu_operation)
`ifdef CU_PERF_CNT_EN
      ,
      .perf_issued          (perf_issued),
      .perf_squashed        (perf_squashed),
      .perf_bubbles         (perf_bubbles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
      instruction = ins;
      instr_valid = v;
      stall       = st;
      flush       = fl;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      flags_nzcv = 4'b0000;
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      tick;
      tick;
      chk("rst_valid", ex_valid, 0);
      chk("rst_rw", ex_reg_write_enable, 0);
      chk("rst_alu", ex_alu_operation, 0);
      chk("rst_hazard", hazard_stall, 0);
      rst_n = 1'b1;

      // ADD AL
      drive(32'hE0810002, 1'b1, 1'b0, 1'b0);
      tick;
      chk("add_valid", ex_valid, 1);
      chk("add_alu", ex_alu_operation, 4'b0000);
      chk("add_rw", ex_reg_write_enable, 1);

      // asynchronous reset mid-cycle
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", ex_valid, 0);
      chk("arst_rw", ex_reg_write_enable, 0);
`ifdef CU_PERF_CNT_EN
      chk("arst_issued", perf_issued, 0);
`endif
      #2 rst_n = 1'b1;
      tick;
      chk("rel_valid", ex_valid, 1);
      chk("rel_alu", ex_alu_operation, 4'b0000);
      chk("rel_rw", ex_reg_write_enable, 1);
`ifdef CU_PERF_CNT_EN
      chk("rel_issued", perf_issued, 1);
`endif

      // condition checks, Z=1
      flags_nzcv = 4'b0100;
      drive(32'h00810002, 1'b1, 1'b0, 1'b0);
      tick;
      chk("addeq_pass", ex_cond_pass, 1);
      chk("addeq_rw", ex_reg_write_enable, 1);
      drive(32'h10810002, 1'b1, 1'b0, 1'b0);
      tick;
      chk("addne_valid", ex_valid, 1);
      chk("addne_pass", ex_cond_pass, 0);
      chk("addne_rw", ex_reg_write_enable, 0);
      chk("addne_mem", ex_mem_enable, 0);
      chk("addne_status", ex_status_bit, 0);
      chk("addne_pc", ex_pc_source_select, 0);
`ifdef CU_PERF_CNT_EN
      chk("addne_squashed", perf_squashed, 1);
`endif

      // flag hazard: SUBS then ADDEQ
      drive(32'hE0510002, 1'b1, 1'b0, 1'b0);
      tick;
      chk("subs_status", ex_status_bit, 1);
      chk("subs_alu", ex_alu_operation, 4'b0010);
      drive(32'h00810002, 1'b1, 1'b0, 1'b0);
      #1;
      chk("haz_on", hazard_stall, 1);
      tick;
      chk("haz_bubble", ex_valid, 0);
      chk("haz_off", hazard_stall, 0);
`ifdef CU_PERF_CNT_EN
      chk("haz_bubbles", perf_bubbles, 1);
`endif
      tick;
      chk("haz_load_valid", ex_valid, 1);
      chk("haz_load_pass", ex_cond_pass, 1);
      chk("haz_load_rw", ex_reg_write_enable, 1);

      // memory
      drive(32'hE5912004, 1'b1, 1'b0, 1'b0);
      tick;
      chk("ldr_mem", ex_mem_enable, 1);
      chk("ldr_rw", ex_mem_rw, 0);
      chk("ldr_src", ex_alu_source_select, 1);
      chk("ldr_alu", ex_alu_operation, 4'b0000);
      chk("ldr_wr", ex_reg_write_enable, 1);
      chk("ldr_m2r", ex_mem_to_reg_select, 1);
      drive(32'hE7412003, 1'b1, 1'b0, 1'b0);
      tick;
      chk("strb_mem", ex_mem_enable, 1);
      chk("strb_rw", ex_mem_rw, 1);
      chk("strb_size", ex_mem_size, 1);
      chk("strb_src", ex_alu_source_select, 0);
      chk("strb_alu", ex_alu_operation, 4'b0010);
      chk("strb_wr", ex_reg_write_enable, 0);

      // BL, stall hold, flush+stall
      drive(32'hEB000010, 1'b1, 1'b0, 1'b0);
      tick;
      chk("bl_pc", ex_pc_source_select, 1);
      chk("bl_wr", ex_reg_write_enable, 1);
      drive(32'hE0810002, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("stall_pc", ex_pc_source_select, 1);
         chk("stall_valid", ex_valid, 1);
      end
      chk("stall_hazard", hazard_stall, 0);
      drive(32'hE0810002, 1'b1, 1'b1, 1'b1);
      tick;
      chk("flush_valid", ex_valid, 0);
      chk("flush_pc", ex_pc_source_select, 0);
      chk("flush_wr", ex_reg_write_enable, 0);
`ifdef CU_PERF_CNT_EN
      chk("flush_squashed", perf_squashed, 2);
`endif

      // more data-processing opcodes
      drive(32'hE1A00001, 1'b1, 1'b0, 1'b0);
      tick;
      chk("mov_alu", ex_alu_operation, 4'b1010);
      chk("mov_wr", ex_reg_write_enable, 1);
      drive(32'hE1500001, 1'b1, 1'b0, 1'b0);
      tick;
      chk("cmp_alu", ex_alu_operation, 4'b0010);
      chk("cmp_wr", ex_reg_write_enable, 0);
      chk("cmp_status", ex_status_bit, 1);
      drive(32'h00810002, 1'b0, 1'b0, 1'b0);
      #1;
      chk("idle_hazard", hazard_stall, 0);
      tick;
      chk("idle_valid", ex_valid, 0);

      // never condition, HI pass/fail
      drive(32'hF0810002, 1'b1, 1'b0, 1'b0);
      tick;
      chk("nv_valid", ex_valid, 1);
      chk("nv_pass", ex_cond_pass, 0);
      chk("nv_wr", ex_reg_write_enable, 0);
      flags_nzcv = 4'b0010;
      drive(32'h80810002, 1'b1, 1'b0, 1'b0);
      tick;
      chk("hi_pass", ex_cond_pass, 1);
      flags_nzcv = 4'b0110;
      tick;
      chk("hi_fail", ex_cond_pass, 0);

      // NOP and class 11
      drive(32'h00000000, 1'b1, 1'b0, 1'b0);
      tick;
      chk("nop_valid", ex_valid, 1);
      chk("nop_wr", ex_reg_write_enable, 0);
      chk("nop_alu", ex_alu_operation, 4'b0000);
      drive(32'hEC000000, 1'b1, 1'b0, 1'b0);
      tick;
      chk("sys_valid", ex_valid, 1);
      chk("sys_wr", ex_reg_write_enable, 0);
      chk("sys_mem", ex_mem_enable, 0);

      // 20 issued ADDs saturate a 4-bit counter
      drive(32'hE0810002, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) tick;
      chk("sat_valid", ex_valid, 1);
`ifdef CU_PERF_CNT_EN
      chk("sat_issued", perf_issued, 15);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
